// File: rtl/dmem_lsu_if.sv
// D-bus bundle between the load/store unit (master) and the data memory (slave).
// The master issues word-aligned requests and holds them until the slave strobes bus_ack.
interface dmem_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit between a single-cycle core's data port and a handshaked word-wide D-bus.
// Decodes the core's memory op, places sub-word stores into byte lanes, extracts and extends
// loads, drops misaligned accesses with a pulse, and stalls the core while an access is in flight.
// A bus access that is not acknowledged within TIMEOUT_CYC busy cycles is abandoned with bus_err.
module dmem_lsu #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_mem_write,
    input  logic [2:0]  i_mem_read,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_bus_err,
    dmem_lsu_if.master  bus
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_rdata;
    logic        r_misalign;
    logic        r_bus_err;
    logic [2:0]  r_load_op;
    logic [1:0]  r_lane;
    logic [CW-1:0] r_count;

    logic        w_is_write;
    logic        w_is_read;
    logic        w_req;
    logic        w_half;
    logic        w_word;
    logic        w_aligned;
    logic        w_start;
    logic        w_misalign;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_load_byte;
    logic [15:0] w_load_half;
    logic [31:0] w_load_data;

    // Decode the core's op: a store beats a simultaneous load, and only naturally aligned
    // halfwords/words may proceed to the bus.
    always_comb begin
        w_is_write = (i_mem_write != 2'b00);
        w_is_read  = !w_is_write && (i_mem_read != 3'd0) && (i_mem_read <= 3'd5);
        w_req      = w_is_write || w_is_read;
        w_half     = w_is_write ? (i_mem_write == 2'b10)
                                : ((i_mem_read == 3'd2) || (i_mem_read == 3'd5));
        w_word     = w_is_write ? (i_mem_write == 2'b11) : (i_mem_read == 3'd3);
        w_aligned  = !((w_half && i_addr[0]) || (w_word && (i_addr[1:0] != 2'b00)));
        w_start    = (r_state == ST_IDLE) && w_req && w_aligned;
        w_misalign = (r_state == ST_IDLE) && w_req && !w_aligned;
        w_timeout  = (TIMEOUT_CYC != 0) && (32'(r_count) == 32'(TIMEOUT_CYC - 1));
    end

    // Steer store data into byte lanes; reads always fetch the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'h0;
        case (i_mem_write)
            2'b01: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'b10: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            2'b11: begin
                w_be    = 4'b1111;
                w_wdata = i_wdata;
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/halfword out of the returned word and extend it for the latched load type.
    always_comb begin
        w_load_byte = 8'h00;
        w_load_data = 32'h0;
        case (r_lane)
            2'd0:    w_load_byte = bus.bus_rdata[7:0];
            2'd1:    w_load_byte = bus.bus_rdata[15:8];
            2'd2:    w_load_byte = bus.bus_rdata[23:16];
            default: w_load_byte = bus.bus_rdata[31:24];
        endcase
        w_load_half = r_lane[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (r_load_op)
            3'd1:    w_load_data = {{24{w_load_byte[7]}}, w_load_byte};
            3'd2:    w_load_data = {{16{w_load_half[15]}}, w_load_half};
            3'd3:    w_load_data = bus.bus_rdata;
            3'd4:    w_load_data = {24'h0, w_load_byte};
            3'd5:    w_load_data = {16'h0, w_load_half};
            default: w_load_data = 32'h0;
        endcase
    end

    // Next-state and stall: the core is held from the request cycle until the access leaves BUSY.
    always_comb begin
        w_next_state = r_state;
        o_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_stall = w_start;
                if (w_start) w_next_state = ST_BUSY;
            end
            ST_BUSY: begin
                o_stall = 1'b1;
                if (bus.bus_ack || w_timeout) w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Bus request registers, load result, timeout counter and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_be    <= 4'h0;
            r_bus_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_load_op   <= 3'd0;
            r_lane      <= 2'd0;
            r_count     <= '0;
        end else begin
            r_misalign <= w_misalign;
            r_bus_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_is_write;
                        r_bus_addr  <= {i_addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_load_op   <= w_is_write ? 3'd0 : i_mem_read;
                        r_lane      <= i_addr[1:0];
                        r_count     <= '0;
                    end else if (w_misalign) begin
                        r_rdata <= 32'h0;
                    end
                end
                ST_BUSY: begin
                    if (bus.bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (r_load_op != 3'd0) r_rdata <= w_load_data;
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_rdata   <= 32'h0;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_be    = r_bus_be;
    assign bus.bus_wdata = r_bus_wdata;
    assign o_rdata       = r_rdata;
    assign o_misalign    = r_misalign;
    assign o_bus_err     = r_bus_err;

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: a table of directed accesses with hand-derived expectations,
// a few multi-cycle corner sequences, then randomized accesses against a lane-level model.
module tb_dmem_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mw;
    logic [2:0]  mr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        busErr;

    int passCount  = 0;
    int checkCount = 0;
    logic [31:0] refRdata;

    dmem_lsu_if bif ();

    dmem_lsu #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_mem_write (mw),
        .i_mem_read  (mr),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_stall     (stall),
        .o_misalign  (misalign),
        .o_bus_err   (busErr),
        .bus         (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mw;
        logic [2:0]  mr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        int          ackDelay;
        logic        expMis;
        logic        expWe;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Lane-level reference: an access covers bytes [lane, lane+size) of the word; stores replicate
    // their low bytes across all lanes; loads gather those bytes and extend from the top one.
    function automatic vec_t modelVec(input logic [1:0] m_w, input logic [2:0] m_r,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      input logic [31:0] rd, input int dly,
                                      input logic [31:0] prevRdata);
        vec_t v;
        int   size;
        int   lane;
        bit   isW;
        logic [31:0] val;
        isW  = (m_w != 2'b00);
        if (isW) size = (m_w == 2'b01) ? 1 : ((m_w == 2'b10) ? 2 : 4);
        else if (m_r == 3'd1 || m_r == 3'd4) size = 1;
        else if (m_r == 3'd2 || m_r == 3'd5) size = 2;
        else size = 4;
        lane = int'(a % 4);
        v.mw = m_w; v.mr = m_r; v.addr = a; v.wdata = wd; v.brdata = rd; v.ackDelay = dly;
        v.expMis  = (lane % size) != 0;
        v.expWe   = isW;
        v.expAddr = a - 32'(lane);
        v.expErr  = !v.expMis && (dly >= TO);
        v.expBe   = 4'h0;
        v.expWdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            v.expBe[i] = isW ? ((i >= lane) && (i < lane + size)) : 1'b1;
            v.expWdata[8*i +: 8] = wd[8*(i % size) +: 8];
        end
        val = 32'h0;
        if (v.expMis || v.expErr) begin
            v.expRdata = 32'h0;
        end else if (isW) begin
            v.expRdata = prevRdata;
        end else begin
            for (int i = 0; i < size; i++) val[8*i +: 8] = rd[8*(lane + i) +: 8];
            if ((m_r == 3'd1 || m_r == 3'd2) && val[8*size - 1])
                for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
            v.expRdata = val;
        end
        return v;
    endfunction

    // Run one core access from an idle cycle through DONE and back to IDLE, acting as the memory.
    task automatic applyStimulus(input vec_t v);
        int stallCycles;
        int reqCycles;
        int k;
        bit timedOut;
        timedOut    = (v.ackDelay >= TO);
        stallCycles = 0;
        reqCycles   = 0;
        mw = v.mw; mr = v.mr; addr = v.addr; wdata = v.wdata;
        #1;
        if (stall) stallCycles++;
        checkOutput("stall_request_cycle", 32'(stall), 32'(!v.expMis));
        @(posedge clk); #1;
        mw = 2'b00; mr = 3'd0;
        if (v.expMis) begin
            #1;
            checkOutput("misalign_pulse", 32'(misalign), 32'd1);
            checkOutput("misalign_no_req", 32'(bif.bus_req), 32'd0);
            checkOutput("misalign_stall", 32'(stall), 32'd0);
            checkOutput("misalign_rdata", rdata, v.expRdata);
            @(posedge clk); #1;
            checkOutput("misalign_pulse_end", 32'(misalign), 32'd0);
            return;
        end
        checkOutput("bus_req_set", 32'(bif.bus_req), 32'd1);
        checkOutput("bus_we", 32'(bif.bus_we), 32'(v.expWe));
        checkOutput("bus_addr", bif.bus_addr, v.expAddr);
        checkOutput("bus_be", 32'(bif.bus_be), 32'(v.expBe));
        if (v.expWe) checkOutput("bus_wdata", bif.bus_wdata, v.expWdata);
        k = 0;
        while (bif.bus_req && k < 20) begin
            if (stall) stallCycles++;
            reqCycles++;
            if (k == v.ackDelay) begin
                bif.bus_ack   = 1'b1;
                bif.bus_rdata = v.brdata;
            end
            @(posedge clk); #1;
            bif.bus_ack   = 1'b0;
            bif.bus_rdata = $urandom;
            k++;
        end
        checkOutput("bus_req_cycles", 32'(reqCycles), timedOut ? 32'(TO) : 32'(v.ackDelay + 1));
        checkOutput("stall_cycles", 32'(stallCycles), timedOut ? 32'(TO + 1) : 32'(v.ackDelay + 2));
        checkOutput("done_stall", 32'(stall), 32'd0);
        checkOutput("done_rdata", rdata, v.expRdata);
        checkOutput("done_bus_err", 32'(busErr), 32'(v.expErr));
        @(posedge clk); #1;
        checkOutput("idle_bus_err_clear", 32'(busErr), 32'd0);
        checkOutput("idle_rdata_held", rdata, v.expRdata);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl [13];
        vec_t v;
        int   opSel;
        logic [1:0] rw;
        logic [2:0] rr;
        logic [31:0] ra;

        //          mw     mr     addr          wdata         brdata        dly mis we  expAddr       be       expWdata      expRdata      err
        tbl[0]  = '{2'b11, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1, 0, 1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 0};
        tbl[1]  = '{2'b00, 3'd1, 32'h0000_0203, 32'h0,         32'h80FF_1234, 0, 0, 0, 32'h0000_0200, 4'b1111, 32'h0,         32'hFFFF_FF80, 0};
        tbl[2]  = '{2'b00, 3'd4, 32'h0000_0203, 32'h0,         32'h80FF_1234, 0, 0, 0, 32'h0000_0200, 4'b1111, 32'h0,         32'h0000_0080, 0};
        tbl[3]  = '{2'b00, 3'd5, 32'h0000_0202, 32'h0,         32'hBEEF_0000, 3, 0, 0, 32'h0000_0200, 4'b1111, 32'h0,         32'h0000_BEEF, 0};
        tbl[4]  = '{2'b00, 3'd2, 32'h0000_0202, 32'h0,         32'hBEEF_0000, 0, 0, 0, 32'h0000_0200, 4'b1111, 32'h0,         32'hFFFF_BEEF, 0};
        tbl[5]  = '{2'b01, 3'd0, 32'h0000_0011, 32'h0000_00AB, 32'h0,        0, 0, 1, 32'h0000_0010, 4'b0010, 32'hABAB_ABAB, 32'hFFFF_BEEF, 0};
        tbl[6]  = '{2'b00, 3'd3, 32'h0000_0102, 32'h0,         32'h0,        0, 1, 0, 32'h0,         4'b0000, 32'h0,         32'h0000_0000, 0};
        tbl[7]  = '{2'b00, 3'd4, 32'h0000_0401, 32'h0,         32'h0000_5500, 0, 0, 0, 32'h0000_0400, 4'b1111, 32'h0,         32'h0000_0055, 0};
        tbl[8]  = '{2'b00, 3'd3, 32'h0000_0400, 32'h0,         32'h0,        9, 0, 0, 32'h0000_0400, 4'b1111, 32'h0,         32'h0000_0000, 1};
        tbl[9]  = '{2'b00, 3'd2, 32'h0000_0301, 32'h0,         32'h0,        0, 1, 0, 32'h0,         4'b0000, 32'h0,         32'h0000_0000, 0};
        tbl[10] = '{2'b00, 3'd3, 32'h0000_0300, 32'h0,         32'h1234_5678, 2, 0, 0, 32'h0000_0300, 4'b1111, 32'h0,         32'h1234_5678, 0};
        tbl[11] = '{2'b10, 3'd0, 32'h0000_0206, 32'h1234_CAFE, 32'h0,        0, 0, 1, 32'h0000_0204, 4'b1100, 32'hCAFE_CAFE, 32'h1234_5678, 0};
        tbl[12] = '{2'b11, 3'd3, 32'h0000_0500, 32'h0BAD_F00D, 32'h0,        1, 0, 1, 32'h0000_0500, 4'b1111, 32'h0BAD_F00D, 32'h1234_5678, 0};

        rst = 1'b1; mw = 2'b00; mr = 3'd0; addr = 32'h0; wdata = 32'h0;
        bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_bus_req", 32'(bif.bus_req), 32'd0);
        checkOutput("reset_bus_we", 32'(bif.bus_we), 32'd0);
        checkOutput("reset_bus_addr", bif.bus_addr, 32'h0);
        checkOutput("reset_bus_be", 32'(bif.bus_be), 32'd0);
        checkOutput("reset_bus_wdata", bif.bus_wdata, 32'h0);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_misalign", 32'(misalign), 32'd0);
        checkOutput("reset_bus_err", 32'(busErr), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed table");
        for (int i = 0; i < 13; i++) applyStimulus(tbl[i]);

        // An ack strobe while idle must not disturb the held load result.
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bif.bus_ack = 1'b0;
        checkOutput("idle_ack_ignored", rdata, 32'h1234_5678);
        checkOutput("idle_ack_no_req", 32'(bif.bus_req), 32'd0);

        // Reserved read codes are treated as no access.
        mr = 3'b110; addr = 32'h0000_0700; #1;
        checkOutput("reserved_read_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mr = 3'd0;
        checkOutput("reserved_read_no_req", 32'(bif.bus_req), 32'd0);
        checkOutput("reserved_read_no_mis", 32'(misalign), 32'd0);

        // Reset during the second busy cycle abandons the access cleanly.
        mw = 2'b11; addr = 32'h0000_0600; wdata = 32'h1122_3344;
        @(posedge clk); #1;
        mw = 2'b00;
        checkOutput("rst_seq_req_up", 32'(bif.bus_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_seq_req_dropped", 32'(bif.bus_req), 32'd0);
        checkOutput("rst_seq_stall", 32'(stall), 32'd0);
        checkOutput("rst_seq_no_err", 32'(busErr), 32'd0);
        checkOutput("rst_seq_no_mis", 32'(misalign), 32'd0);
        checkOutput("rst_seq_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        checkOutput("rst_seq_still_idle", 32'(bif.bus_req), 32'd0);
        applyStimulus(modelVec(2'b11, 3'd0, 32'h0000_0604, 32'h5566_7788, 32'h0, 0, 32'h0));
        refRdata = 32'h0;

        $display("[TB] randomized accesses");
        for (int n = 0; n < 60; n++) begin
            opSel = $urandom_range(0, 7);
            if (opSel < 3) begin
                rw = 2'(opSel + 1);
                rr = 3'($urandom_range(0, 7));
            end else begin
                rw = 2'b00;
                rr = 3'(opSel - 2);
            end
            ra = {$urandom, 2'b00} | 32'($urandom_range(0, 3));
            v = modelVec(rw, rr, ra, $urandom, $urandom, int'($urandom_range(0, 5)), refRdata);
            applyStimulus(v);
            refRdata = v.expRdata;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
